// File: rtl/snn_weight_loader_pkg.sv
// Shared definitions for the spiking-network weight loader:
// register address map, FSM and error encodings, weight widths.
package snn_pkg;

  // Register address map (low three bits of the ADDR byte)
  localparam logic [2:0] ADDR_W1  = 3'd0;
  localparam logic [2:0] ADDR_W2  = 3'd1;
  localparam logic [2:0] ADDR_W3  = 3'd2;
  localparam logic [2:0] ADDR_W4  = 3'd3;
  localparam logic [2:0] ADDR_W5  = 3'd4;
  localparam logic [2:0] ADDR_W6  = 3'd5;
  localparam logic [2:0] ADDR_TH1 = 3'd6;
  localparam logic [2:0] ADDR_TH2 = 3'd7;

  // Highest legal full-byte address
  localparam logic [7:0] ADDR_MAX = 8'd7;

  // Hidden-layer weights are signed, output-layer weights unsigned
  localparam int W_HID_W = 5;
  localparam int W_OUT_W = 4;

  // Thresholds come out of reset at unit value
  localparam logic [7:0] TH_RESET = 8'h01;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_CHK   = 2'd1,
    ERR_ADDR  = 2'd2,
    ERR_ABORT = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHK    = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

endpackage

// File: rtl/snn_weight_loader_if.sv
// Byte-serial host command bus: host drives valid/data, loader drives ready.
interface snn_weight_loader_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/snn_weight_loader_sat_clamp.sv
// Combinational saturator: 8-bit input (signed or unsigned) clamped into
// an OUT_W-bit result of the chosen signedness.
module snn_sat_clamp #(
  parameter int OUT_W  = 5,
  parameter bit SIGNED = 1'b1
) (
  input  logic [7:0]       i_data,
  output logic [OUT_W-1:0] o_data
);

  localparam int MAXV = SIGNED ? (1 << (OUT_W - 1)) - 1 : (1 << OUT_W) - 1;
  localparam int MINV = SIGNED ? -(1 << (OUT_W - 1)) : 0;
  localparam logic signed [8:0] MAX9 = 9'(MAXV);
  localparam logic signed [8:0] MIN9 = 9'(MINV);

  // One extra bit lets both interpretations compare as signed values
  logic signed [8:0] w_ext;
  assign w_ext = {(SIGNED ? i_data[7] : 1'b0), i_data};

  // Clamp to the representable range, otherwise truncate (value already fits)
  always_comb begin
    o_data = w_ext[OUT_W-1:0];
    if (w_ext > MAX9) begin
      o_data = MAX9[OUT_W-1:0];
    end else if (w_ext < MIN9) begin
      o_data = MIN9[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/snn_weight_loader.sv
// Framed byte-serial configuration writer: HEADER, ADDR, DATA, CHK frames
// are validated and committed into the network's weight/threshold registers.
module snn_weight_loader
  import snn_pkg::*;
#(
  parameter int         TIMEOUT = 255,
  parameter logic [7:0] HEADER  = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      write_mode,
  snn_weight_loader_if.slave        cmd,
  output logic signed [W_HID_W-1:0] weight1,
  output logic signed [W_HID_W-1:0] weight2,
  output logic signed [W_HID_W-1:0] weight3,
  output logic signed [W_HID_W-1:0] weight4,
  output logic [W_OUT_W-1:0]        weight5,
  output logic [W_OUT_W-1:0]        weight6,
  output logic [7:0]                threshold1,
  output logic [7:0]                threshold2,
  output logic                      load_done,
  output logic [1:0]                err_code,
  output logic [7:0]                commit_count
);

  // Abort fires on the idle cycle that would bring the counter to TIMEOUT
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e     r_state, w_state_next;
  err_e       r_err, w_err_next;
  logic [7:0] r_tmo, w_tmo_next;
  logic [7:0] r_addr, r_data;
  logic       w_ready, w_accept, w_commit;
  logic [W_HID_W-1:0] w_hid_sat;
  logic [W_OUT_W-1:0] w_out_sat;

  assign w_ready       = write_mode && (r_state != ST_COMMIT);
  assign w_accept      = cmd.cmd_valid && w_ready;
  assign cmd.cmd_ready = w_ready;
  assign err_code      = r_err;

  snn_sat_clamp #(.OUT_W(W_HID_W), .SIGNED(1'b1)) u_sat_hid (
    .i_data (r_data),
    .o_data (w_hid_sat)
  );

  snn_sat_clamp #(.OUT_W(W_OUT_W), .SIGNED(1'b0)) u_sat_out (
    .i_data (r_data),
    .o_data (w_out_sat)
  );

  // FSM state, error code and inter-byte timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_err   <= ERR_NONE;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      r_tmo   <= w_tmo_next;
    end
  end

  // Next-state logic: frame sequencing, validation, abort and timeout
  always_comb begin
    w_state_next = r_state;
    w_err_next   = r_err;
    w_tmo_next   = r_tmo;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tmo_next = '0;
        if (w_accept && (cmd.cmd_data == HEADER)) begin
          w_state_next = ST_ADDR;
          w_err_next   = ERR_NONE;
        end
      end
      ST_ADDR, ST_DATA, ST_CHK: begin
        if (!write_mode) begin
          w_state_next = ST_IDLE;
          w_err_next   = ERR_ABORT;
          w_tmo_next   = '0;
        end else if (w_accept) begin
          w_tmo_next = '0;
          if (r_state == ST_ADDR) begin
            w_state_next = ST_DATA;
          end else if (r_state == ST_DATA) begin
            w_state_next = ST_CHK;
          end else if (cmd.cmd_data != (r_addr ^ r_data)) begin
            w_state_next = ST_IDLE;
            w_err_next   = ERR_CHK;
          end else if (r_addr > ADDR_MAX) begin
            w_state_next = ST_IDLE;
            w_err_next   = ERR_ADDR;
          end else begin
            w_state_next = ST_COMMIT;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_state_next = ST_IDLE;
          w_err_next   = ERR_ABORT;
          w_tmo_next   = '0;
        end else begin
          w_tmo_next = r_tmo + 8'd1;
        end
      end
      ST_COMMIT: begin
        // Commit completes even if write_mode drops this cycle
        w_commit     = 1'b1;
        w_state_next = ST_IDLE;
        w_tmo_next   = '0;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_tmo_next   = '0;
      end
    endcase
  end

  // Latch the ADDR and DATA bytes of the frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      if (r_state == ST_ADDR) r_addr <= cmd.cmd_data;
      if (r_state == ST_DATA) r_data <= cmd.cmd_data;
    end
  end

  // Commit the validated value into its target register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight1      <= '0;
      weight2      <= '0;
      weight3      <= '0;
      weight4      <= '0;
      weight5      <= '0;
      weight6      <= '0;
      threshold1   <= TH_RESET;
      threshold2   <= TH_RESET;
      load_done    <= 1'b0;
      commit_count <= '0;
    end else begin
      load_done <= w_commit;
      if (w_commit) begin
        commit_count <= commit_count + 8'd1;
        case (r_addr[2:0])
          ADDR_W1:  weight1    <= w_hid_sat;
          ADDR_W2:  weight2    <= w_hid_sat;
          ADDR_W3:  weight3    <= w_hid_sat;
          ADDR_W4:  weight4    <= w_hid_sat;
          ADDR_W5:  weight5    <= w_out_sat;
          ADDR_W6:  weight6    <= w_out_sat;
          ADDR_TH1: threshold1 <= r_data;
          default:  threshold2 <= r_data;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snn_weight_loader.sv
// Directed bench for snn_weight_loader: frames, saturation, errors, abort,
// timeout, counter wrap and asynchronous reset mid-frame.
module tb_snn_weight_loader;

  logic       clk;
  logic       rst_n;
  logic       write_mode;
  logic [4:0] weight1, weight2, weight3, weight4;
  logic [3:0] weight5, weight6;
  logic [7:0] threshold1, threshold2;
  logic       load_done;
  logic [1:0] err_code;
  logic [7:0] commit_count;

  int total = 0;
  int bad   = 0;

  snn_weight_loader_if cmd_bus ();

  snn_weight_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_mode   (write_mode),
    .cmd          (cmd_bus),
    .weight1      (weight1),
    .weight2      (weight2),
    .weight3      (weight3),
    .weight4      (weight4),
    .weight5      (weight5),
    .weight6      (weight6),
    .threshold1   (threshold1),
    .threshold2   (threshold2),
    .load_done    (load_done),
    .err_code     (err_code),
    .commit_count (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_data  = b;
    tick();
    cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
    send_byte(c);
  endtask

  initial begin
    rst_n             = 1'b0;
    write_mode        = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_data  = 8'h00;
    #12;
    // reset values
    check("rst_ready_wm0", {31'b0, cmd_bus.cmd_ready}, 32'h0);
    write_mode = 1'b1;
    #1;
    check("rst_ready_wm1", {31'b0, cmd_bus.cmd_ready}, 32'h1);
    check("rst_weight1", {27'b0, weight1}, 32'h0);
    check("rst_th1", {24'b0, threshold1}, 32'h01);
    check("rst_th2", {24'b0, threshold2}, 32'h01);
    check("rst_load_done", {31'b0, load_done}, 32'h0);
    check("rst_err", {30'b0, err_code}, 32'h0);
    check("rst_count", {24'b0, commit_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // weight3 = -3, commit one cycle after CHK
    send_frame(8'h02, 8'hFD, 8'hFF);
    check("commit_ready", {31'b0, cmd_bus.cmd_ready}, 32'h0);
    check("w3_before", {27'b0, weight3}, 32'h0);
    check("ld_before", {31'b0, load_done}, 32'h0);
    tick();
    check("w3_neg3", {27'b0, weight3}, 32'h1D);
    check("ld_pulse", {31'b0, load_done}, 32'h1);
    check("count1", {24'b0, commit_count}, 32'h1);
    tick();
    check("ld_low", {31'b0, load_done}, 32'h0);

    // saturation cases
    send_frame(8'h00, 8'h40, 8'h40); tick();
    check("w1_sat_pos", {27'b0, weight1}, 32'h0F);
    send_frame(8'h05, 8'h20, 8'h25); tick();
    check("w6_sat", {28'b0, weight6}, 32'hF);
    send_frame(8'h00, 8'h80, 8'h80); tick();
    check("w1_sat_neg", {27'b0, weight1}, 32'h10);
    send_frame(8'h04, 8'h07, 8'h03); tick();
    check("w5_plain", {28'b0, weight5}, 32'h7);
    check("count5", {24'b0, commit_count}, 32'h5);

    // bad checksum
    send_frame(8'h06, 8'h10, 8'h00);
    check("err_chk", {30'b0, err_code}, 32'h1);
    check("chk_ready", {31'b0, cmd_bus.cmd_ready}, 32'h1);
    tick();
    check("chk_no_ld", {31'b0, load_done}, 32'h0);
    check("chk_th1", {24'b0, threshold1}, 32'h01);

    // bad address
    send_frame(8'h09, 8'h00, 8'h09);
    check("err_addr", {30'b0, err_code}, 32'h2);
    tick();
    check("addr_count", {24'b0, commit_count}, 32'h5);

    // write_mode dropped mid-frame
    send_byte(8'hA5);
    check("hdr_clear1", {30'b0, err_code}, 32'h0);
    send_byte(8'h07);
    write_mode = 1'b0;
    #1;
    check("wm0_ready", {31'b0, cmd_bus.cmd_ready}, 32'h0);
    tick();
    check("err_abort", {30'b0, err_code}, 32'h3);
    check("abort_th2", {24'b0, threshold2}, 32'h01);
    write_mode = 1'b1;
    tick();

    // inter-byte timeout
    send_byte(8'hA5);
    check("hdr_clear2", {30'b0, err_code}, 32'h0);
    send_byte(8'h01);
    repeat (254) tick();
    check("tmo_254", {30'b0, err_code}, 32'h0);
    tick();
    check("tmo_255", {30'b0, err_code}, 32'h3);
    send_frame(8'h07, 8'h33, 8'h34); tick();
    check("post_tmo_th2", {24'b0, threshold2}, 32'h33);
    check("count6", {24'b0, commit_count}, 32'h6);

    // commit counter wrap
    for (int i = 6; i < 255; i++) begin
      send_frame(8'h06, 8'(i), 8'h06 ^ 8'(i));
      tick();
    end
    check("count255", {24'b0, commit_count}, 32'hFF);
    send_frame(8'h06, 8'hFF, 8'hF9); tick();
    check("count_wrap", {24'b0, commit_count}, 32'h0);
    check("wrap_th1", {24'b0, threshold1}, 32'hFF);

    // asynchronous reset while in DATA
    send_byte(8'hA5);
    send_byte(8'h03);
    rst_n = 1'b0;
    #1;
    check("arst_w3", {27'b0, weight3}, 32'h0);
    check("arst_w1", {27'b0, weight1}, 32'h0);
    check("arst_w5", {28'b0, weight5}, 32'h0);
    check("arst_w6", {28'b0, weight6}, 32'h0);
    check("arst_th1", {24'b0, threshold1}, 32'h01);
    check("arst_th2", {24'b0, threshold2}, 32'h01);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // stale partial frame must not complete; a fresh frame commits
    send_byte(8'hF0);
    send_byte(8'hF3);
    tick();
    check("arst_discard", {24'b0, commit_count}, 32'h0);
    send_frame(8'h03, 8'hF0, 8'hF3); tick();
    check("w4_min", {27'b0, weight4}, 32'h10);
    check("arst_count1", {24'b0, commit_count}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
